// File: rtl/key_ctrl_pkg.sv
// Shared key indices, scan-state type and counter command encoding for the key scan controller.
package key_ctrl_pkg;

   localparam int KEY_UP  = 0;
   localparam int KEY_DN  = 1;
   localparam int KEY_RST = 2;

   localparam int SLOT_W = 8;
   typedef logic [SLOT_W-1:0] scan_state_t;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_UP,
      CMD_DN,
      CMD_RST
   } cmd_t;

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: state flips after DEB_SAMPLES consecutive disagreeing strobed samples.
// State and press pulse update one clock after the deciding strobe; no backpressure.
module key_debounce #(
   parameter int DEB_SAMPLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_strobe,
   input  logic i_sample,
   output logic o_state,
   output logic o_press
);

   localparam int CW = $clog2(DEB_SAMPLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          state_q, state_d;
   logic          press_q, press_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         state_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         press_q <= press_d;
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      press_d = 1'b0;
      if (i_strobe) begin
         if (i_sample == state_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = i_sample;
            press_d = i_sample;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign o_state = state_q;
   assign o_press = press_q;

endmodule

// File: rtl/key_scan_counter_ctrl.sv
// Scans keys, debounces them and drives an up/down/reset counter to active-low LEDs; command lands
// two clocks after the deciding sample, no backpressure. KEY_AUTOREPEAT_EN adds held-key auto-repeat.
module key_scan_counter_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int          N_KEYS      = 3,
   parameter int          SCAN_DIV    = 50000,
   parameter int          DEB_SAMPLES = 4,
   parameter int          CNT_W       = 4,
   parameter int unsigned CNT_INIT    = 0
`ifdef KEY_AUTOREPEAT_EN
   ,
   parameter int          REPEAT_DLY  = 10,
   parameter int          REPEAT_PER  = 3
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [N_KEYS-1:0] o_scan,
   input  logic              i_sense,
   output logic [N_KEYS-1:0] o_keys,
   output logic [CNT_W-1:0]  o_count,
   output logic [CNT_W-1:0]  o_led_n,
   output logic              o_evt_up,
   output logic              o_evt_dn,
   output logic              o_evt_rst,
   output logic              o_wrap
);

   localparam int TW = $clog2(SCAN_DIV);
   localparam logic [TW-1:0]    TIMER_LAST = TW'(SCAN_DIV - 1);
   localparam scan_state_t      LAST_SLOT  = scan_state_t'(N_KEYS - 1);
   localparam logic [CNT_W-1:0] CNT_INIT_V = CNT_W'(CNT_INIT);

   logic              sync1_q, sync2_q;
   logic [TW-1:0]     timer_q, timer_d;
   scan_state_t       state_q, state_d;
   logic [N_KEYS-1:0] scan_q, scan_d;
   logic              slot_end;
   logic [N_KEYS-1:0] strobe, keys, press;
   cmd_t              cmd;
   logic [CNT_W-1:0]  count_q, count_d, led_q;
   logic              up_q, up_d, dn_q, dn_d, rst_q, rst_d, wrap_q, wrap_d;

   // Idle level of the sense line is high (no key pulling it low).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= i_sense;
         sync2_q <= sync1_q;
      end
   end

   assign slot_end = (timer_q == TIMER_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
         state_q <= '0;
         scan_q  <= ~N_KEYS'(1);
      end else begin
         timer_q <= timer_d;
         state_q <= state_d;
         scan_q  <= scan_d;
      end
   end

   always_comb begin
      timer_d = slot_end ? '0 : timer_q + 1'b1;
      state_d = state_q;
      if (slot_end) begin
         state_d = (state_q == LAST_SLOT) ? '0 : state_q + 1'b1;
      end
   end

   // Drive is derived from the next state so the column moves on the same edge as the slot.
   always_comb begin
      scan_d = ~(N_KEYS'(1) << state_d);
   end

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      assign strobe[k] = slot_end && (state_q == scan_state_t'(k));
      key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_strobe (strobe[k]),
         .i_sample (~sync2_q),
         .o_state  (keys[k]),
         .o_press  (press[k])
      );
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_DLY + REPEAT_PER + 1);

   logic          rep_on_q, rep_first_q, rep_up_q;
   logic [RW-1:0] rep_cnt_q;
   logic          frame_end, rep_fire;

   assign frame_end = slot_end && (state_q == LAST_SLOT);
   assign rep_fire  = rep_on_q && frame_end &&
                      ((rep_cnt_q + 1'b1) == (rep_first_q ? RW'(REPEAT_DLY) : RW'(REPEAT_PER)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_on_q    <= 1'b0;
         rep_first_q <= 1'b0;
         rep_up_q    <= 1'b0;
         rep_cnt_q   <= '0;
      end else if (cmd == CMD_RST || (rep_on_q && !(rep_up_q ? keys[KEY_UP] : keys[KEY_DN]))) begin
         rep_on_q <= 1'b0;
      end else if ((cmd == CMD_UP || cmd == CMD_DN) && !rep_fire) begin
         rep_on_q    <= 1'b1;
         rep_first_q <= 1'b1;
         rep_up_q    <= (cmd == CMD_UP);
         rep_cnt_q   <= '0;
      end else if (rep_on_q && frame_end) begin
         rep_cnt_q <= rep_fire ? '0 : rep_cnt_q + 1'b1;
         if (rep_fire) begin
            rep_first_q <= 1'b0;
         end
      end
   end
`endif

   // Presses arrive one key per cycle, so a simple priority chain never drops a command.
   always_comb begin
      cmd = CMD_NONE;
      if (press[KEY_RST]) begin
         cmd = CMD_RST;
      end else if (!keys[KEY_RST]) begin
         if (press[KEY_UP]) begin
            cmd = CMD_UP;
         end else if (press[KEY_DN]) begin
            cmd = CMD_DN;
         end
`ifdef KEY_AUTOREPEAT_EN
         else if (rep_fire) begin
            cmd = rep_up_q ? CMD_UP : CMD_DN;
         end
`endif
      end
   end

   always_comb begin
      count_d = count_q;
      up_d    = 1'b0;
      dn_d    = 1'b0;
      rst_d   = 1'b0;
      wrap_d  = 1'b0;
      case (cmd)
         CMD_UP: begin
            count_d = count_q + 1'b1;
            up_d    = 1'b1;
            wrap_d  = &count_q;
         end
         CMD_DN: begin
            count_d = count_q - 1'b1;
            dn_d    = 1'b1;
            wrap_d  = ~|count_q;
         end
         CMD_RST: begin
            count_d = CNT_INIT_V;
            rst_d   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= CNT_INIT_V;
         led_q   <= ~CNT_INIT_V;
         up_q    <= 1'b0;
         dn_q    <= 1'b0;
         rst_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         led_q   <= ~count_d;
         up_q    <= up_d;
         dn_q    <= dn_d;
         rst_q   <= rst_d;
         wrap_q  <= wrap_d;
      end
   end

   assign o_scan    = scan_q;
   assign o_keys    = keys;
   assign o_count   = count_q;
   assign o_led_n   = led_q;
   assign o_evt_up  = up_q;
   assign o_evt_dn  = dn_q;
   assign o_evt_rst = rst_q;
   assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_key_scan_counter_ctrl.sv
// Bench for key_scan_counter_ctrl: a key-matrix model drives i_sense, a cycle-count model predicts outputs.
module tb_key_scan_counter_ctrl;

   localparam int NK = 3;
   localparam int SD = 4;
   localparam int DS = 2;
   localparam int CW = 4;
   localparam int FRAME = SD * NK;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] o_scan, o_keys;
   logic          i_sense;
   logic [CW-1:0] o_count, o_led_n;
   logic          o_evt_up, o_evt_dn, o_evt_rst, o_wrap;
   logic [NK-1:0] key_down = '0;

   int checks = 0;
   int failures = 0;
   int n_up = 0, n_dn = 0, n_rst = 0, n_wrap = 0;

   // A held key connects its column drive to the common sense line.
   assign i_sense = ~|(key_down & ~o_scan);

   always #5 clk = ~clk;

   key_scan_counter_ctrl #(
      .N_KEYS(NK), .SCAN_DIV(SD), .DEB_SAMPLES(DS), .CNT_W(CW), .CNT_INIT(0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .o_scan    (o_scan),
      .i_sense   (i_sense),
      .o_keys    (o_keys),
      .o_count   (o_count),
      .o_led_n   (o_led_n),
      .o_evt_up  (o_evt_up),
      .o_evt_dn  (o_evt_dn),
      .o_evt_rst (o_evt_rst),
      .o_wrap    (o_wrap)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m = edges since reset release; slot = (m/SD)%NK; the key sample decided at edge m
   // (m%SD==0) sees i_sense from two edges earlier; a toggle at edge m commands at edge m+1.
   int          m;
   bit          sa, sb, sc;
   bit [NK-1:0] ek;
   int          dcnt[NK];
   int          ecount;
   bit          eup, edn, erst, ewrap;
   int          pend;

   always @(negedge clk) begin
      int k;
      bit smp;
      if (!rst_n) begin
         m = 0; ek = '0; ecount = 0; pend = 0;
         {eup, edn, erst, ewrap} = '0;
         for (int i = 0; i < NK; i++) dcnt[i] = 0;
         sa = 1'b1; sb = 1'b1; sc = 1'b1;
      end else begin
         m++;
         {eup, edn, erst, ewrap} = '0;
         case (pend)
            1: begin ewrap = (ecount == 15); ecount = (ecount + 1) % 16; eup = 1'b1; end
            2: begin ewrap = (ecount == 0); ecount = (ecount + 15) % 16; edn = 1'b1; end
            3: begin ecount = 0; erst = 1'b1; end
            default: ;
         endcase
         pend = 0;
         if (m % SD == 0) begin
            k = ((m - 1) / SD) % NK;
            smp = !sc;
            if (smp == ek[k]) dcnt[k] = 0;
            else begin
               dcnt[k]++;
               if (dcnt[k] == DS) begin
                  dcnt[k] = 0;
                  ek[k] = smp;
                  if (smp) begin
                     if (k == 2) pend = 3;
                     else if (k < 2 && !ek[2]) pend = k + 1;
                  end
               end
            end
         end
         n_up += int'(o_evt_up); n_dn += int'(o_evt_dn);
         n_rst += int'(o_evt_rst); n_wrap += int'(o_wrap);
      end
      chk("scan", o_scan, ((1 << NK) - 1) ^ (1 << ((m / SD) % NK)));
      chk("keys", o_keys, ek);
      chk("count", o_count, ecount);
      chk("led_n", o_led_n, 15 - ecount);
      chk("evt_up", o_evt_up, eup);
      chk("evt_dn", o_evt_dn, edn);
      chk("evt_rst", o_evt_rst, erst);
      chk("wrap", o_wrap, ewrap);
      sc = sb; sb = sa; sa = i_sense;
   end

   task automatic press_key(input int k, input int frames);
      @(posedge clk); #2 key_down[k] = 1'b1;
      repeat (frames * FRAME) @(posedge clk);
      #2 key_down[k] = 1'b0;
      repeat (4 * FRAME) @(posedge clk);
   endtask

   task automatic clear_counts();
      n_up = 0; n_dn = 0; n_rst = 0; n_wrap = 0;
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      int up_before;
      repeat (3) @(posedge clk);
      @(negedge clk); #1 rst_n = 1'b1;

      // Scan sequence after reset: 110 for edges 1..3, 101 at edge 4, 011 at edge 8, 110 at edge 12.
      repeat (3) @(posedge clk); #2 chk("scan_e3", o_scan, 3'b110);
      @(posedge clk); #2 chk("scan_e4", o_scan, 3'b101);
      repeat (4) @(posedge clk); #2 chk("scan_e8", o_scan, 3'b011);
      repeat (4) @(posedge clk); #2 chk("scan_e12", o_scan, 3'b110);
      chk("idle_count", o_count, 4'd0);
      chk("idle_led", o_led_n, 4'b1111);

      clear_counts();
      press_key(0, 3);
      chk("up_once_evts", n_up, 1);
      chk("up_once_count", o_count, 4'd1);
      chk("up_once_led", o_led_n, 4'b1110);

      press_key(1, 1);
      chk("glitch_dn_evts", n_dn, 0);
      chk("glitch_keys", o_keys, 3'b000);
      chk("glitch_count", o_count, 4'd1);

      press_key(1, 3);
      chk("dn_to_zero", o_count, 4'd0);
      chk("dn_nowrap", n_wrap, 0);
      press_key(1, 3);
      chk("dn_wrap_count", o_count, 4'd15);
      chk("dn_wrap_evts", n_wrap, 1);
      press_key(0, 3);
      chk("up_wrap_count", o_count, 4'd0);
      chk("up_wrap_evts", n_wrap, 2);

      repeat (5) press_key(0, 3);
      chk("count_five", o_count, 4'd5);
      clear_counts();
      @(posedge clk); #2 key_down[2] = 1'b1;
      repeat (4 * FRAME) @(posedge clk);
      #2 chk("rst_key_count", o_count, 4'd0);
      chk("rst_key_evts", n_rst, 1);
      up_before = n_up;
      press_key(0, 3);
      chk("up_while_rst", o_count, 4'd0);
      chk("up_while_rst_evts", n_up, up_before);
      key_down[2] = 1'b0;
      repeat (4 * FRAME) @(posedge clk);
      #2 chk("rst_released", o_keys, 3'b000);

      press_key(0, 3);
      chk("pre_reset_count", o_count, 4'd1);
      @(posedge clk); #2 key_down[0] = 1'b1;
      repeat (FRAME) @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk); #1;
      chk("async_rst_count", o_count, 4'd0);
      chk("async_rst_led", o_led_n, 4'b1111);
      chk("async_rst_scan", o_scan, 3'b110);
      repeat (3) @(posedge clk);
      @(negedge clk); #1 rst_n = 1'b1;
      clear_counts();
      repeat (FRAME) @(posedge clk);
      #2 chk("no_evt_on_release", n_up, 0);
      chk("held_count", o_count, 4'd0);
      repeat (4 * FRAME) @(posedge clk);
      #2 chk("redebounce_evts", n_up, 1);
      chk("redebounce_count", o_count, 4'd1);
      key_down[0] = 1'b0;
      repeat (4 * FRAME) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
